// File: rtl/oldland_operand_fetch_pkg.sv
// rtl/oldland_operand_fetch_pkg.sv - types shared by the operand fetch stage
`include "oldland_defines.vh"

package oldland_operand_fetch_pkg;

  localparam int REG_W  = `OLDLAND_REG_W;
  localparam int DATA_W = `OLDLAND_DATA_W;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // Contents of the OF holding register.
  typedef struct packed {
    logic     valid;
    reg_idx_t ra_sel;
    reg_idx_t rb_sel;
    reg_idx_t rd;
    logic     uses_ra;
    logic     uses_rb;
    logic     writes_rd;
    data_t    pc;
    data_t    imm;
  } of_t;

endpackage

// File: rtl/oldland_operand_fetch_if.sv
// rtl/oldland_operand_fetch_if.sv - decode-side and execute-side handshakes of the stage
interface oldland_operand_fetch_if;
  import oldland_operand_fetch_pkg::*;

  logic     dec_valid;
  logic     dec_ready;
  reg_idx_t dec_ra_sel;
  reg_idx_t dec_rb_sel;
  reg_idx_t dec_rd_sel;
  logic     dec_uses_ra;
  logic     dec_uses_rb;
  logic     dec_writes_rd;
  data_t    dec_pc;
  data_t    dec_imm;

  logic     out_valid;
  logic     out_ready;
  data_t    out_ra;
  data_t    out_rb;
  reg_idx_t out_rd;
  logic     out_writes_rd;
  data_t    out_pc;
  data_t    out_imm;

  modport master (
    input  dec_valid, dec_ra_sel, dec_rb_sel, dec_rd_sel,
    input  dec_uses_ra, dec_uses_rb, dec_writes_rd, dec_pc, dec_imm,
    output dec_ready,
    output out_valid, out_ra, out_rb, out_rd, out_writes_rd, out_pc, out_imm,
    input  out_ready
  );

  modport slave (
    output dec_valid, dec_ra_sel, dec_rb_sel, dec_rd_sel,
    output dec_uses_ra, dec_uses_rb, dec_writes_rd, dec_pc, dec_imm,
    input  dec_ready,
    input  out_valid, out_ra, out_rb, out_rd, out_writes_rd, out_pc, out_imm,
    output out_ready
  );

endinterface

// File: rtl/oldland_defines.vh
// rtl/oldland_defines.vh - shared widths for the oldland operand fetch slice
`ifndef OLDLAND_DEFINES_VH
`define OLDLAND_DEFINES_VH
`define OLDLAND_REG_W  4
`define OLDLAND_DATA_W 32
`endif

// File: rtl/oldland_operand_mux.sv
// rtl/oldland_operand_mux.sv - per-operand forwarding select and load-use hazard detect
module oldland_operand_mux
  import oldland_operand_fetch_pkg::*;
#(
  parameter bit FWD_MEM = 1'b1
) (
  input  reg_idx_t sel,
  input  logic     uses,
  input  logic     bp_flag,
  input  data_t    bp_val,
  input  data_t    rf_val,
  input  logic     ex_valid,
  input  reg_idx_t ex_rd,
  input  data_t    ex_val,
  input  logic     ex_is_load,
  input  logic     mem_valid,
  input  reg_idx_t mem_rd,
  input  data_t    mem_val,
  output data_t    operand,
  output logic     hazard
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    operand = '0;
    hazard  = 1'b0;
    ex_hit  = ex_valid && (ex_rd == sel);
    mem_hit = mem_valid && (mem_rd == sel);
    if (uses) begin
      // A load in execute has no data yet; the hazard holds the stage until it reaches memory.
      hazard = (ex_hit && ex_is_load) || (!FWD_MEM && mem_hit);
      if (ex_hit && !ex_is_load) begin
        operand = ex_val;
      end else if (FWD_MEM && mem_hit) begin
        operand = mem_val;
      end else if (bp_flag) begin
        operand = bp_val;
      end else begin
        operand = rf_val;
      end
    end
  end

endmodule

// File: rtl/oldland_operand_fetch.sv
// rtl/oldland_operand_fetch.sv - operand fetch stage: regfile read, forwarding, load-use stall
module oldland_operand_fetch
  import oldland_operand_fetch_pkg::*;
#(
  parameter bit FWD_MEM = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  oldland_operand_fetch_if.master io,
  output reg_idx_t ra_sel,
  output reg_idx_t rb_sel,
  input  data_t    rf_ra,
  input  data_t    rf_rb,
  input  logic     wb_en,
  input  reg_idx_t wb_sel,
  input  data_t    wb_val,
  input  logic     ex_fwd_valid,
  input  reg_idx_t ex_fwd_rd,
  input  data_t    ex_fwd_val,
  input  logic     ex_fwd_is_load,
  input  logic     mem_fwd_valid,
  input  reg_idx_t mem_fwd_rd,
  input  data_t    mem_fwd_val,
  input  logic     flush,
  input  logic     dbg_en
);

  of_t   of_q, of_d;
  logic  bp_a_flag_q, bp_a_flag_d;
  logic  bp_b_flag_q, bp_b_flag_d;
  data_t bp_a_val_q, bp_a_val_d;
  data_t bp_b_val_q, bp_b_val_d;
  logic  dbg_q, dbg_d;

  logic  advance;
  logic  hazard;
  logic  haz_a, haz_b;
  data_t op_a, op_b;

  oldland_operand_mux #(.FWD_MEM(FWD_MEM)) u_mux_a (
    .sel        (of_q.ra_sel),
    .uses       (of_q.uses_ra),
    .bp_flag    (bp_a_flag_q),
    .bp_val     (bp_a_val_q),
    .rf_val     (rf_ra),
    .ex_valid   (ex_fwd_valid),
    .ex_rd      (ex_fwd_rd),
    .ex_val     (ex_fwd_val),
    .ex_is_load (ex_fwd_is_load),
    .mem_valid  (mem_fwd_valid),
    .mem_rd     (mem_fwd_rd),
    .mem_val    (mem_fwd_val),
    .operand    (op_a),
    .hazard     (haz_a)
  );

  oldland_operand_mux #(.FWD_MEM(FWD_MEM)) u_mux_b (
    .sel        (of_q.rb_sel),
    .uses       (of_q.uses_rb),
    .bp_flag    (bp_b_flag_q),
    .bp_val     (bp_b_val_q),
    .rf_val     (rf_rb),
    .ex_valid   (ex_fwd_valid),
    .ex_rd      (ex_fwd_rd),
    .ex_val     (ex_fwd_val),
    .ex_is_load (ex_fwd_is_load),
    .mem_valid  (mem_fwd_valid),
    .mem_rd     (mem_fwd_rd),
    .mem_val    (mem_fwd_val),
    .operand    (op_b),
    .hazard     (haz_b)
  );

  always_comb begin
    hazard = of_q.valid && (haz_a || haz_b);
    // dbg_q covers the cycle after the debugger releases port A, whose read data is still the debugger's.
    advance = !dbg_en && (!of_q.valid || (io.out_ready && !hazard && !dbg_q));
    io.dec_ready = advance || flush;

    ra_sel = advance ? io.dec_ra_sel : of_q.ra_sel;
    rb_sel = advance ? io.dec_rb_sel : of_q.rb_sel;

    of_d = of_q;
    if (flush) begin
      of_d.valid = 1'b0;
    end else if (advance) begin
      of_d.valid     = io.dec_valid;
      of_d.ra_sel    = io.dec_ra_sel;
      of_d.rb_sel    = io.dec_rb_sel;
      of_d.rd        = io.dec_rd_sel;
      of_d.uses_ra   = io.dec_uses_ra;
      of_d.uses_rb   = io.dec_uses_rb;
      of_d.writes_rd = io.dec_writes_rd;
      of_d.pc        = io.dec_pc;
      of_d.imm       = io.dec_imm;
    end

    // Read-before-write regfile: a same-edge write is only visible through this capture.
    bp_a_flag_d = wb_en && (wb_sel == ra_sel);
    bp_b_flag_d = wb_en && (wb_sel == rb_sel);
    bp_a_val_d  = wb_val;
    bp_b_val_d  = wb_val;
    dbg_d       = dbg_en;

    io.out_valid     = of_q.valid && !hazard && !dbg_en && !dbg_q;
    io.out_ra        = op_a;
    io.out_rb        = op_b;
    io.out_rd        = of_q.rd;
    io.out_writes_rd = of_q.writes_rd;
    io.out_pc        = of_q.pc;
    io.out_imm       = of_q.imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_q        <= '0;
      bp_a_flag_q <= 1'b0;
      bp_b_flag_q <= 1'b0;
      bp_a_val_q  <= '0;
      bp_b_val_q  <= '0;
      dbg_q       <= 1'b0;
    end else begin
      of_q        <= of_d;
      bp_a_flag_q <= bp_a_flag_d;
      bp_b_flag_q <= bp_b_flag_d;
      bp_a_val_q  <= bp_a_val_d;
      bp_b_val_q  <= bp_b_val_d;
      dbg_q       <= dbg_d;
    end
  end

endmodule

// File: tb/tb_oldland_operand_fetch.sv
// tb/tb_oldland_operand_fetch.sv - directed self-checking bench for the operand fetch stage
module tb_oldland_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ra_sel, rb_sel;
  logic [31:0] rf_ra, rf_rb;
  logic        wb_en;
  logic [3:0]  wb_sel;
  logic [31:0] wb_val;
  logic        ex_fwd_valid, ex_fwd_is_load;
  logic [3:0]  ex_fwd_rd;
  logic [31:0] ex_fwd_val;
  logic        mem_fwd_valid;
  logic [3:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_val;
  logic        flush, dbg_en;
  logic [31:0] rf [16];

  int n_total = 0;
  int n_bad   = 0;

  oldland_operand_fetch_if io ();

  oldland_operand_fetch #(.FWD_MEM(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io             (io),
    .ra_sel         (ra_sel),
    .rb_sel         (rb_sel),
    .rf_ra          (rf_ra),
    .rf_rb          (rf_rb),
    .wb_en          (wb_en),
    .wb_sel         (wb_sel),
    .wb_val         (wb_val),
    .ex_fwd_valid   (ex_fwd_valid),
    .ex_fwd_rd      (ex_fwd_rd),
    .ex_fwd_val     (ex_fwd_val),
    .ex_fwd_is_load (ex_fwd_is_load),
    .mem_fwd_valid  (mem_fwd_valid),
    .mem_fwd_rd     (mem_fwd_rd),
    .mem_fwd_val    (mem_fwd_val),
    .flush          (flush),
    .dbg_en         (dbg_en)
  );

  always #5 clk = ~clk;

  // Registered-read, read-before-write regfile; the debugger takes port A and reads r15.
  always @(posedge clk) begin
    rf_ra <= dbg_en ? rf[15] : rf[ra_sel];
    rf_rb <= rf[rb_sel];
    if (wb_en) rf[wb_sel] <= wb_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic dec(input logic [3:0] ra, input logic [3:0] rb, input logic ua, input logic ub,
                     input logic [3:0] rd, input logic [31:0] pc);
    io.dec_valid     = 1'b1;
    io.dec_ra_sel    = ra;
    io.dec_rb_sel    = rb;
    io.dec_rd_sel    = rd;
    io.dec_uses_ra   = ua;
    io.dec_uses_rb   = ub;
    io.dec_writes_rd = 1'b1;
    io.dec_pc        = pc;
    io.dec_imm       = pc + 32'h1000;
  endtask

  task automatic idle();
    io.dec_valid   = 1'b0;
    io.dec_ra_sel  = 4'd0;
    io.dec_rb_sel  = 4'd0;
    io.dec_uses_ra = 1'b0;
    io.dec_uses_rb = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h100 + i;
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33; rf[4] = 32'h44;
    rf[5] = 32'h55; rf[6] = 32'h66; rf[15] = 32'hF0F0;
    rst_n = 1'b0;
    wb_en = 0; wb_sel = 0; wb_val = 0;
    ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_val = 0; ex_fwd_is_load = 0;
    mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_val = 0;
    flush = 0; dbg_en = 0;
    io.out_ready = 1'b1; io.dec_rd_sel = 0; io.dec_writes_rd = 0; io.dec_pc = 0; io.dec_imm = 0;
    idle();
    repeat (2) next_cycle();
    sample();
    check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    check("rst_dec_ready", {31'd0, io.dec_ready}, 32'd1);
    check("rst_out_ra", io.out_ra, 32'd0);
    check("rst_out_rb", io.out_rb, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // basic read r1, r2
    dec(4'd1, 4'd2, 1, 1, 4'd5, 32'h100);
    sample();
    check("basic_ra_sel", {28'd0, ra_sel}, 32'd1);
    next_cycle();
    idle();
    sample();
    check("basic_valid", {31'd0, io.out_valid}, 32'd1);
    check("basic_ra", io.out_ra, 32'h11);
    check("basic_rb", io.out_rb, 32'h22);
    check("basic_rd", {28'd0, io.out_rd}, 32'd5);
    check("basic_pc", io.out_pc, 32'h100);
    check("basic_imm", io.out_imm, 32'h1100);

    // EX wins over MEM; rb unused reads as 0
    next_cycle();
    dec(4'd1, 4'd7, 1, 0, 4'd6, 32'h104);
    next_cycle();
    idle();
    ex_fwd_valid = 1; ex_fwd_rd = 4'd1; ex_fwd_val = 32'hAAAA5555;
    mem_fwd_valid = 1; mem_fwd_rd = 4'd1; mem_fwd_val = 32'h1;
    sample();
    check("ex_fwd_ra", io.out_ra, 32'hAAAA5555);
    check("unused_rb", io.out_rb, 32'd0);
    next_cycle();
    ex_fwd_valid = 0;
    dec(4'd1, 4'd0, 1, 0, 4'd6, 32'h108);
    next_cycle();
    idle();
    sample();
    check("mem_fwd_ra", io.out_ra, 32'h1);
    next_cycle();
    mem_fwd_valid = 0;

    // load-use on r3
    dec(4'd3, 4'd0, 1, 0, 4'd7, 32'h10C);
    next_cycle();
    dec(4'd2, 4'd0, 1, 0, 4'd8, 32'h110);
    ex_fwd_valid = 1; ex_fwd_rd = 4'd3; ex_fwd_is_load = 1; ex_fwd_val = 32'hBAD;
    sample();
    check("lu_out_valid", {31'd0, io.out_valid}, 32'd0);
    check("lu_dec_ready", {31'd0, io.dec_ready}, 32'd0);
    check("lu_ra_sel", {28'd0, ra_sel}, 32'd3);
    next_cycle();
    ex_fwd_valid = 0; ex_fwd_is_load = 0;
    mem_fwd_valid = 1; mem_fwd_rd = 4'd3; mem_fwd_val = 32'hDEAD;
    sample();
    check("lu_resume_valid", {31'd0, io.out_valid}, 32'd1);
    check("lu_resume_ra", io.out_ra, 32'hDEAD);
    check("lu_resume_pc", io.out_pc, 32'h10C);
    next_cycle();
    mem_fwd_valid = 0;
    idle();
    sample();
    check("lu_next_pc", io.out_pc, 32'h110);
    check("lu_next_ra", io.out_ra, 32'h22);

    // same-edge writeback to r4
    next_cycle();
    dec(4'd0, 4'd4, 0, 1, 4'd9, 32'h114);
    wb_en = 1; wb_sel = 4'd4; wb_val = 32'h1234;
    next_cycle();
    wb_en = 0;
    idle();
    sample();
    check("wb_bypass_rb", io.out_rb, 32'h1234);
    check("wb_bypass_ra", io.out_ra, 32'd0);

    // backpressure for three cycles
    next_cycle();
    dec(4'd1, 4'd2, 1, 1, 4'd10, 32'h200);
    next_cycle();
    dec(4'd5, 4'd6, 1, 1, 4'd11, 32'h204);
    io.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp_valid", {31'd0, io.out_valid}, 32'd1);
      check("bp_pc", io.out_pc, 32'h200);
      check("bp_ra", io.out_ra, 32'h11);
      check("bp_rb", io.out_rb, 32'h22);
      check("bp_dec_ready", {31'd0, io.dec_ready}, 32'd0);
      check("bp_ra_sel", {28'd0, ra_sel}, 32'd1);
      next_cycle();
    end
    io.out_ready = 1'b1;
    sample();
    check("rel_pc", io.out_pc, 32'h200);
    check("rel_dec_ready", {31'd0, io.dec_ready}, 32'd1);
    check("rel_ra_sel", {28'd0, ra_sel}, 32'd5);
    next_cycle();
    idle();
    sample();
    check("rel_next_pc", io.out_pc, 32'h204);
    check("rel_next_ra", io.out_ra, 32'h55);
    check("rel_next_rb", io.out_rb, 32'h66);

    // flush beats a simultaneous decode
    next_cycle();
    dec(4'd1, 4'd0, 1, 0, 4'd12, 32'h300);
    flush = 1'b1;
    sample();
    check("flush_dec_ready", {31'd0, io.dec_ready}, 32'd1);
    next_cycle();
    flush = 1'b0;
    idle();
    sample();
    check("flush_out_valid", {31'd0, io.out_valid}, 32'd0);

    // debugger owns port A
    next_cycle();
    dec(4'd2, 4'd0, 1, 0, 4'd13, 32'h400);
    next_cycle();
    idle();
    dbg_en = 1'b1;
    sample();
    check("dbg_out_valid", {31'd0, io.out_valid}, 32'd0);
    check("dbg_dec_ready", {31'd0, io.dec_ready}, 32'd0);
    next_cycle();
    dbg_en = 1'b0;
    sample();
    check("dbg_fall_valid", {31'd0, io.out_valid}, 32'd0);
    next_cycle();
    sample();
    check("dbg_after_valid", {31'd0, io.out_valid}, 32'd1);
    check("dbg_after_ra", io.out_ra, 32'h22);
    check("dbg_after_pc", io.out_pc, 32'h400);

    // async reset while an instruction is held
    next_cycle();
    dec(4'd1, 4'd2, 1, 1, 4'd14, 32'h500);
    next_cycle();
    io.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, io.out_valid}, 32'd0);
    check("arst_out_ra", io.out_ra, 32'd0);
    check("arst_dec_ready", {31'd0, io.dec_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
